// File: rtl/dpram_rr_arbiter.sv
// dpram_rr_arbiter: round-robin arbiter sharing an internal dual-port RAM among NUM_REQ requesters.
// Optional DPRAM_ARB_CONFLICT_CNT_EN adds a saturating collision counter output.
module dpram_rr_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ-1:0]            we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] wdata,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            rvalid,
  output logic [NUM_REQ*DATA_WIDTH-1:0] rdata
`ifdef DPRAM_ARB_CONFLICT_CNT_EN
  ,
  output logic [15:0]                   conflict_cnt
`endif
);
  localparam int PW = $clog2(NUM_REQ);
  logic [PW-1:0] rr_ptr, a_idx, b_idx, tb_o;
  logic a_v, b_v, collide, a_go, b_go, a_wr, b_wr, tb_v;
  logic [NUM_REQ-1:0] rv_nxt;
  logic [ADDR_WIDTH-1:0] addr_u [NUM_REQ];
  logic [DATA_WIDTH-1:0] wd_u [NUM_REQ];
  logic [ADDR_WIDTH-1:0] a_addr, b_addr;
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] q_a, q_b;
  int scan_i;
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] x);
    return (int'(x) == NUM_REQ - 1) ? '0 : x + 1'b1;
  endfunction
  for (genvar g = 0; g < NUM_REQ; g++) begin : g_slice
    assign addr_u[g] = addr[g*ADDR_WIDTH +: ADDR_WIDTH];
    assign wd_u[g]   = wdata[g*DATA_WIDTH +: DATA_WIDTH];
    // port B result goes to its owner; everyone else sees port A
    assign rdata[g*DATA_WIDTH +: DATA_WIDTH] = (tb_v && int'(tb_o) == g) ? q_b : q_a;
  end
  always_comb begin
    a_v    = 1'b0;
    b_v    = 1'b0;
    a_idx  = '0;
    b_idx  = '0;
    scan_i = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_i = (int'(rr_ptr) + k) % NUM_REQ;
      if (req[scan_i] && a_v && !b_v) begin
        b_v   = 1'b1;
        b_idx = PW'(scan_i);
      end
      if (req[scan_i] && !a_v) begin
        a_v   = 1'b1;
        a_idx = PW'(scan_i);
      end
    end
  end
  assign a_addr  = addr_u[a_idx];
  assign b_addr  = addr_u[b_idx];
  assign collide = b_v && a_addr == b_addr && (we[a_idx] || we[b_idx]);
  assign a_go    = a_v && !rst;
  assign b_go    = b_v && !collide && !rst;
  assign a_wr    = a_go && we[a_idx];
  assign b_wr    = b_go && we[b_idx];
  always_comb begin
    gnt    = '0;
    rv_nxt = '0;
    if (a_go) gnt[a_idx] = 1'b1;
    if (b_go) gnt[b_idx] = 1'b1;
    if (a_go && !we[a_idx]) rv_nxt[a_idx] = 1'b1;
    if (b_go && !we[b_idx]) rv_nxt[b_idx] = 1'b1;
  end
  always_ff @(posedge clk) begin
    if (a_wr) mem[a_addr] <= wd_u[a_idx];
    if (b_wr) mem[b_addr] <= wd_u[b_idx];
    q_a <= mem[a_addr];
    q_b <= mem[b_addr];
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr <= '0;
      rvalid <= '0;
      tb_v   <= 1'b0;
      tb_o   <= '0;
    end else begin
      rr_ptr <= b_go ? nxt(b_idx) : a_go ? nxt(a_idx) : rr_ptr;
      rvalid <= rv_nxt;
      tb_v   <= b_go && !we[b_idx];
      tb_o   <= b_idx;
    end
  end
`ifdef DPRAM_ARB_CONFLICT_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) conflict_cnt <= '0;
    else if (collide && conflict_cnt != 16'hFFFF) conflict_cnt <= conflict_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_dpram_rr_arbiter.sv
// tb_dpram_rr_arbiter: directed vector table plus reset corner sequence for dpram_rr_arbiter.
module tb_dpram_rr_arbiter;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0, we = '0;
  logic [15:0] addr = '0;
  logic [31:0] wdata = '0;
  logic [3:0]  gnt, rvalid;
  logic [31:0] rdata;
  int nvec = 0, nbad = 0;
`ifdef DPRAM_ARB_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt;
`endif
  dpram_rr_arbiter #(.NUM_REQ(4), .DATA_WIDTH(8), .ADDR_WIDTH(4)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata),
    .gnt(gnt), .rvalid(rvalid), .rdata(rdata)
`ifdef DPRAM_ARB_CONFLICT_CNT_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );
  always #5 clk = ~clk;
  typedef struct {
    logic [3:0]  req;
    logic [3:0]  we;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [3:0]  gnt;
    logic [3:0]  rv;
    logic [31:0] rd;
  } vec_t;
  vec_t tbl [26];
  function automatic vec_t mk(logic [3:0] r, logic [3:0] w, logic [15:0] a, logic [31:0] d,
                              logic [3:0] g, logic [3:0] v, logic [31:0] q);
    vec_t t;
    t.req = r; t.we = w; t.addr = a; t.wdata = d; t.gnt = g; t.rv = v; t.rd = q;
    return t;
  endfunction
  task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %h expected %h", n, act, exp);
    end
  endtask
  task automatic chk_out(string n, logic [3:0] g, logic [3:0] v, logic [31:0] q);
    chk({n, " gnt"}, 32'(gnt), 32'(g));
    chk({n, " rvalid"}, 32'(rvalid), 32'(v));
    for (int j = 0; j < 4; j++)
      if (v[j]) chk($sformatf("%s rdata[%0d]", n, j), 32'(rdata[j*8 +: 8]), 32'(q[j*8 +: 8]));
  endtask
  initial begin
    for (int i = 0; i < 5; i++) tbl[i] = mk(4'h0, 4'h0, 16'h0000, 32'h0, 4'h0, 4'h0, 32'h0);
    tbl[5]  = mk(4'h1, 4'h1, 16'h0003, 32'h000000A5, 4'h1, 4'h0, 32'h0);
    tbl[6]  = mk(4'h1, 4'h0, 16'h0003, 32'h0,        4'h1, 4'h0, 32'h0);
    tbl[7]  = mk(4'h0, 4'h0, 16'h0000, 32'h0,        4'h0, 4'h1, 32'h000000A5);
    tbl[8]  = mk(4'h8, 4'h8, 16'h9000, 32'h3C000000, 4'h8, 4'h0, 32'h0);
    tbl[9]  = mk(4'hF, 4'h0, 16'h9393, 32'h0,        4'h3, 4'h0, 32'h0);
    tbl[10] = mk(4'hF, 4'h0, 16'h9393, 32'h0,        4'hC, 4'h3, 32'h00003CA5);
    tbl[11] = mk(4'hF, 4'h0, 16'h9393, 32'h0,        4'h3, 4'hC, 32'h3CA50000);
    tbl[12] = mk(4'hF, 4'h0, 16'h9393, 32'h0,        4'hC, 4'h3, 32'h00003CA5);
    tbl[13] = mk(4'h0, 4'h0, 16'h0000, 32'h0,        4'h0, 4'hC, 32'h3CA50000);
    tbl[14] = mk(4'h6, 4'h2, 16'h0550, 32'h00007700, 4'h2, 4'h0, 32'h0);
    tbl[15] = mk(4'h4, 4'h0, 16'h0500, 32'h0,        4'h4, 4'h0, 32'h0);
    tbl[16] = mk(4'h0, 4'h0, 16'h0000, 32'h0,        4'h0, 4'h4, 32'h00770000);
    tbl[17] = mk(4'h4, 4'h4, 16'h0700, 32'h005A0000, 4'h4, 4'h0, 32'h0);
    tbl[18] = mk(4'h3, 4'h0, 16'h0077, 32'h0,        4'h3, 4'h0, 32'h0);
    tbl[19] = mk(4'h0, 4'h0, 16'h0000, 32'h0,        4'h0, 4'h3, 32'h00005A5A);
    tbl[20] = mk(4'h5, 4'h1, 16'h0505, 32'h00000011, 4'h4, 4'h0, 32'h0);
    tbl[21] = mk(4'h1, 4'h1, 16'h0005, 32'h00000011, 4'h1, 4'h4, 32'h00770000);
    tbl[22] = mk(4'h0, 4'h0, 16'h0000, 32'h0,        4'h0, 4'h0, 32'h0);
    tbl[23] = mk(4'h6, 4'h6, 16'h0210, 32'h00222100, 4'h6, 4'h0, 32'h0);
    tbl[24] = mk(4'h6, 4'h0, 16'h0210, 32'h0,        4'h6, 4'h0, 32'h0);
    tbl[25] = mk(4'h0, 4'h0, 16'h0000, 32'h0,        4'h0, 4'h6, 32'h00222100);
    repeat (2) @(negedge clk);
    #1 chk_out("in_reset", 4'h0, 4'h0, 32'h0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 26; i++) begin
      @(negedge clk);
      req = tbl[i].req; we = tbl[i].we; addr = tbl[i].addr; wdata = tbl[i].wdata;
      #1 chk_out($sformatf("vec%0d", i), tbl[i].gnt, tbl[i].rv, tbl[i].rd);
    end
`ifdef DPRAM_ARB_CONFLICT_CNT_EN
    chk("conflict_cnt", 32'(conflict_cnt), 32'd2);
`endif
    // read grant, then async reset right after the capturing edge
    @(negedge clk);
    req = 4'h1; we = 4'h0; addr = 16'h0003;
    #1 chk("pre_rst gnt", 32'(gnt), 32'h1);
    @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("rst rvalid", 32'(rvalid), 32'h0);
    chk("rst gnt", 32'(gnt), 32'h0);
`ifdef DPRAM_ARB_CONFLICT_CNT_EN
    chk("rst conflict_cnt", 32'(conflict_cnt), 32'h0);
`endif
    @(negedge clk);
    #1 chk("rst hold rvalid", 32'(rvalid), 32'h0);
    rst = 1'b0;
    req = 4'hF; addr = 16'h3333;
    #1 chk("post_rst gnt", 32'(gnt), 32'h3);
    chk("post_rst rvalid", 32'(rvalid), 32'h0);
    @(negedge clk);
    req = 4'h0;
    #1 chk_out("post_rst read", 4'h0, 4'h3, 32'h0000A5A5);
    @(negedge clk);
    #1 chk("post_rst idle rvalid", 32'(rvalid), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
    $finish;
  end
endmodule
